// File: rtl/lsu_mem_access.sv
// lsu_mem_access: memory-access stage of the load/store unit.
// Accepts one load/store at a time, validates funct3 and alignment, drives a
// word-wide data-memory port with byte lanes, and returns the raw read word
// together with the original instruction and address.
// Optional feature: define LSU_ACCESS_TIMEOUT_EN to abort an ACCESS that
// waits TIMEOUT_CYCLES cycles without mem_ack (reported as rsp_err).
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instruction,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instruction,
  output logic [31:0] rsp_address,
  output logic [31:0] rsp_read_data,
  output logic        rsp_err
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // The timeout counter must be able to hold TIMEOUT_CYCLES.
  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_to_w
    $error("lsu_mem_access: TO_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef LSU_ACCESS_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  logic [2:0] req_f3;
  logic [6:0] req_opc;
  logic       req_err;
  logic       is_load_q;
  logic [3:0] lane_be;

  // Classify the incoming request: legal funct3 per opcode, then natural alignment.
  always_comb begin
    req_opc = req_instruction[6:0];
    req_f3  = req_instruction[14:12];
    req_err = 1'b0;
    if (req_opc == OPC_LOAD) begin
      if (req_f3 == 3'b011 || req_f3 == 3'b110 || req_f3 == 3'b111) begin
        req_err = 1'b1;
      end
    end else if (req_opc == OPC_STORE) begin
      if (req_f3 >= 3'b011) begin
        req_err = 1'b1;
      end
    end else begin
      req_err = 1'b1;
    end
    if (req_f3[1:0] == 2'b01 && req_address[0]) begin
      req_err = 1'b1;
    end
    if (req_f3[1:0] == 2'b10 && req_address[1:0] != 2'b00) begin
      req_err = 1'b1;
    end
  end

  // Byte-lane enables for the held access; loads use the same lanes as stores.
  always_comb begin
    case (instr_q[13:12])
      2'b00:   lane_be = 4'b0001 << addr_q[1:0];
      2'b01:   lane_be = 4'b0011 << addr_q[1:0];
      default: lane_be = 4'b1111;
    endcase
  end

  assign is_load_q = (instr_q[6:0] == OPC_LOAD);

  // Next-state and captured-field logic for the three-state access FSM.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_ACCESS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          instr_d = req_instruction;
          addr_d  = req_address;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = req_err;
`ifdef LSU_ACCESS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          rdata_d = is_load_q ? mem_rdata : 32'd0;
          state_d = RESP;
        end
`ifdef LSU_ACCESS_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured request/response registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef LSU_ACCESS_TIMEOUT_EN
  // Cycles spent waiting for mem_ack in the current access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // req_ready is masked by rst so it stays low for the whole reset pulse.
  assign req_ready       = (state_q == IDLE) & ~rst;
  assign mem_req         = (state_q == ACCESS);
  assign mem_we          = (state_q == ACCESS) & ~is_load_q;
  assign mem_be          = (state_q == ACCESS) ? lane_be : 4'b0000;
  assign mem_addr        = {addr_q[31:2], 2'b00};
  assign mem_wdata       = wdata_q << {addr_q[1:0], 3'b000};
  assign rsp_valid       = (state_q == RESP);
  assign rsp_instruction = instr_q;
  assign rsp_address     = addr_q;
  assign rsp_read_data   = rdata_q;
  assign rsp_err         = err_q;

endmodule
